fetch_align_buffer: RTL and testbench
=====================================

# fetch_align_buffer

Instruction fetch aligner between instruction memory and the IF/ID pipeline register. It issues word-aligned fetch requests and buffers the returned words as halfwords. It then presents one complete raw instruction per handshake, either 16-bit RVC or 32-bit, together with its PC, to the decompressor / IF/ID stage. Redirects from branch resolution or jumps flush the buffer and drop any in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, PC of the first instruction after reset.
- clk  in  1  clock, all state on rising edge.
- rstn  in  1  asynchronous active-low reset.
- redirect_valid  in  1  flush and restart fetch at redirect_pc.
- redirect_pc  in  32  new PC; bit 0 ignored.
- mem_req_valid  out  1  fetch request valid.
- mem_req_addr  out  32  word-aligned fetch address, bits [1:0] always 0.
- mem_req_ready  in  1  memory accepts the request when valid && ready.
- mem_rsp_valid  in  1  read data valid; in order; at earliest 1 cycle after accept.
- mem_rsp_data  in  32  read word; the low halfword is at the lower address.
- out_valid  out  1  complete instruction available.
- out_ready  in  1  consumer takes the instruction when valid && ready.
- out_instr  out  32  raw instruction; when compressed it is {16'h0, hw}.
- out_pc  out  32  PC of out_instr.
- out_is_compressed  out  1  out_instr is 16-bit RVC.

## Operation
- **Buffer:** 4-entry halfword FIFO, count 0..4. head_pc is the PC of the oldest halfword.
- **Instruction length:** if head halfword bits [1:0] != 2'b11 the instruction is compressed and needs count >= 1. Otherwise it is 32-bit and needs count >= 2.
- **out_valid:** asserted exactly when the length condition holds.
- **Output fields:**
  - out_instr = {hw1, hw0} for a 32-bit instruction, where hw0 is the head halfword and hw1 the next one.
  - out_pc = head_pc.
- **Pop:** on output handshake, remove 1 or 2 halfwords; head_pc += 2 or 4 (32-bit wrap).
- **Request issue:** mem_req_valid = !redirect_valid && !outstanding && count <= 2 (count after any pop that cycle is not used; the registered count is the one tested).
  - mem_req_addr = fetch_addr.
  - On accept: outstanding <= 1, fetch_addr += 4.
  - At most one outstanding request.
- **Response:** if outstanding && !drop, push halfwords.
  - skip_low = 0: push both halfwords, low first.
  - skip_low = 1: push only the high halfword, then clear skip_low.
  - outstanding <= 0 in both cases.
  - Push and pop in the same cycle are legal. Capacity is guaranteed by the issue rule.
- **Redirect:** has highest priority and takes one cycle.
  - count <= 0; head_pc <= {redirect_pc[31:1], 1'b0}; fetch_addr <= {redirect_pc[31:2], 2'b00}; skip_low <= redirect_pc[1].
  - If a request is outstanding and no response arrives this cycle, drop <= 1. The next response is discarded and clears both drop and outstanding.
  - A response arriving in the redirect cycle is discarded and clears outstanding; drop stays 0.
  - An output handshake in the redirect cycle is ignored, because the consumer is flushed too.
- **Reset values:**
  - count = 0, head_pc = RESET_PC, fetch_addr = {RESET_PC[31:2], 2'b00}, skip_low = RESET_PC[1].
  - outstanding = 0, drop = 0.
  - Outputs during reset: out_valid = 0, mem_req_valid = 0, out_instr = 0, out_pc = RESET_PC, out_is_compressed = 0.
- **Reset mid-operation:** all state returns to the reset values immediately (asynchronous). Any response that arrives later with outstanding = 0 is ignored.

## Timing
- Request accepted at cycle N, response at N+k (k >= 1). out_valid is asserted in cycle N+k+1 if the data completes an instruction.
- First request after rstn deasserts: mem_req_valid = 1 in the first clock cycle.
- mem_req_addr and mem_req_valid hold stable while mem_req_ready = 0. They drop only on a redirect.
- out_valid, out_instr, out_pc and out_is_compressed hold stable while out_valid && !out_ready, unless a redirect occurs.
- Redirect at cycle R:
  - out_valid = 0 and mem_req_valid = 0 in cycle R (combinational gating).
  - The new request, with the new address, is presented in R+1.
- Steady-state throughput:
  - Full-width stream: one 32-bit instruction per 2 cycles when memory latency is 1, limited by the single outstanding request.
  - Compressed stream: 2 instructions per response.

## Test plan
- **Reset fetch:** RESET_PC=0, word@0 = 0x00500093, latency 1 → mem_req_addr 0x0 in cycle 1. out_valid in cycle 3 with out_instr 0x00500093, out_pc 0x0, out_is_compressed 0.
- **Mixed RVC/straddle:** word@0 = 0x00934505, word@4 = 0x45050050 → three outputs:
  - (0x00004505, pc 0x0, c=1)
  - (0x00500093, pc 0x2, c=0)
  - (0x00004505, pc 0x6, c=1)
- **Redirect with request outstanding:** redirect_pc=0x102 one cycle after an accept at 0x8 → the stale response is dropped and the next request goes to 0x100. Given word@0x100 = 0x4505xxxx, the first output is 0x00004505 with pc 0x102.
- **Redirect coincident with mem_rsp_valid:** no output results from that data. mem_req_addr equals the redirect word address in the next cycle.
- **Backpressure:** out_ready=0 for 6 cycles with a compressed stream → count reaches 4 and mem_req_valid stays 0 while count > 2. out_instr and out_pc remain constant. On release, drain in order with no lost halfword.
- **Memory stall and mid-run reset:** mem_req_ready=0 for 4 cycles → mem_req_addr is held. Asserting rstn low mid-stall → next cycle out_valid 0, mem_req_valid 0, out_pc RESET_PC.

Source files
------------

// File: rtl/fetch_align_buffer.sv
// fetch_align_buffer: word-aligned fetch front end that re-slices returned
// memory words into halfwords and hands out one complete RVC (16-bit) or
// full-width (32-bit) instruction per handshake, with its PC.
module fetch_align_buffer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rstn,
  // flush / restart
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  // fetch request
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  // fetch response
  input  logic        mem_rsp_valid,
  input  logic [31:0] mem_rsp_data,
  // instruction output
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        out_is_compressed
);

  localparam int DEPTH = 4;

  // Halfword ring buffer. Contents need no reset: a slot is only looked at
  // once the occupancy count says it has been written.
  logic [15:0] r_buf [DEPTH];
  logic [1:0]  r_rd_ptr;
  logic [2:0]  r_count;
  logic [31:0] r_head_pc;

  // Fetch-side state
  logic [31:0] r_fetch_addr;
  logic        r_skip_low;    // first word after a redirect to pc[1]=1: keep only the high half
  logic        r_outstanding; // one request in flight
  logic        r_drop;        // in-flight response belongs to a flushed stream

  // Combinational helpers
  logic [1:0]  w_rd_ptr1;
  logic [1:0]  w_wr_ptr;
  logic [15:0] w_hw0;
  logic [15:0] w_hw1;
  logic        w_is_c;
  logic        w_len_ok;
  logic        w_pop;
  logic [2:0]  w_pop_n;
  logic        w_push;
  logic [2:0]  w_push_n;
  logic [2:0]  w_count_next;
  logic        w_req_fire;
  logic        w_rsp_seen;
  logic [DEPTH-1:0] w_slot_we;
  logic [15:0]      w_slot_wdata [DEPTH];

  // Head of buffer and instruction-length decode
  assign w_rd_ptr1 = r_rd_ptr + 2'd1;
  assign w_hw0     = r_buf[r_rd_ptr];
  assign w_hw1     = r_buf[w_rd_ptr1];
  assign w_is_c    = (w_hw0[1:0] != 2'b11);
  assign w_len_ok  = w_is_c ? (r_count != 3'd0) : (r_count >= 3'd2);

  // Output port; the consumer is flushed together with us on a redirect.
  assign out_valid         = rstn && !redirect_valid && w_len_ok;
  assign out_instr         = !w_len_ok ? 32'h0 :
                             (w_is_c ? {16'h0, w_hw0} : {w_hw1, w_hw0});
  assign out_pc            = r_head_pc;
  assign out_is_compressed = w_len_ok && w_is_c;

  // Issue only when the worst-case response (two halfwords) is sure to fit.
  assign mem_req_valid = rstn && !redirect_valid && !r_outstanding && (r_count <= 3'd2);
  assign mem_req_addr  = r_fetch_addr;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  // Pop and push amounts for this cycle
  assign w_pop        = out_valid && out_ready;
  assign w_pop_n      = !w_pop ? 3'd0 : (w_is_c ? 3'd1 : 3'd2);
  assign w_rsp_seen   = mem_rsp_valid && r_outstanding;
  assign w_push       = w_rsp_seen && !r_drop && !redirect_valid;
  assign w_push_n     = !w_push ? 3'd0 : (r_skip_low ? 3'd1 : 3'd2);
  assign w_count_next = r_count + w_push_n - w_pop_n;

  // Pushes only happen while count <= 2, so the write pointer never wraps
  // past the read pointer.
  assign w_wr_ptr = r_rd_ptr + r_count[1:0];

  // Per-slot write enable and data: slot at wr_ptr takes the low half (or the
  // high half when skipping), the following slot takes the high half.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    logic [1:0] w_off;
    assign w_off            = 2'(gi) - w_wr_ptr;
    assign w_slot_we[gi]    = w_push &&
                              ((w_off == 2'd0) || ((w_off == 2'd1) && !r_skip_low));
    assign w_slot_wdata[gi] = ((w_off == 2'd0) && !r_skip_low) ? mem_rsp_data[15:0]
                                                               : mem_rsp_data[31:16];
  end

  // Halfword storage writes
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (w_slot_we[i]) begin
        r_buf[i] <= w_slot_wdata[i];
      end
    end
  end

  // Buffer occupancy, read pointer and head PC; a redirect empties the buffer
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_count   <= 3'd0;
      r_rd_ptr  <= 2'd0;
      r_head_pc <= RESET_PC;
    end else if (redirect_valid) begin
      r_count   <= 3'd0;
      r_rd_ptr  <= 2'd0;
      r_head_pc <= {redirect_pc[31:1], 1'b0};
    end else begin
      r_count  <= w_count_next;
      r_rd_ptr <= r_rd_ptr + w_pop_n[1:0];
      if (w_pop) begin
        r_head_pc <= r_head_pc + {28'h0, w_pop_n, 1'b0};
      end
    end
  end

  // Fetch address, skip flag, outstanding request and stale-response tracking
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_fetch_addr  <= {RESET_PC[31:2], 2'b00};
      r_skip_low    <= RESET_PC[1];
      r_outstanding <= 1'b0;
      r_drop        <= 1'b0;
    end else if (redirect_valid) begin
      r_fetch_addr <= {redirect_pc[31:2], 2'b00};
      r_skip_low   <= redirect_pc[1];
      if (r_outstanding) begin
        if (mem_rsp_valid) begin
          // the in-flight response lands now and is simply not pushed
          r_outstanding <= 1'b0;
          r_drop        <= 1'b0;
        end else begin
          r_drop <= 1'b1;
        end
      end
    end else begin
      if (w_req_fire) begin
        r_outstanding <= 1'b1;
        r_fetch_addr  <= r_fetch_addr + 32'd4;
      end
      if (w_rsp_seen) begin
        r_outstanding <= 1'b0;
        r_drop        <= 1'b0;
        if (!r_drop) begin
          r_skip_low <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_fetch_align_buffer.sv
// tb_fetch_align_buffer: directed scenarios against a small in-bench memory
// responder with configurable latency; expected values are hand-derived.
module tb_fetch_align_buffer;

  logic        clk;
  logic        rstn;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_rsp_valid;
  logic [31:0] mem_rsp_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        out_is_compressed;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int lat   = 1;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } rsp_t;
  rsp_t rq[$];

  logic [31:0] mem [logic [31:0]];

  logic [31:0] got_instr [8];
  logic [31:0] got_pc    [8];
  logic        got_c     [8];
  int          got_n;

  fetch_align_buffer #(.RESET_PC(32'h0000_0000)) dut (
    .clk              (clk),
    .rstn             (rstn),
    .redirect_valid   (redirect_valid),
    .redirect_pc      (redirect_pc),
    .mem_req_valid    (mem_req_valid),
    .mem_req_addr     (mem_req_addr),
    .mem_req_ready    (mem_req_ready),
    .mem_rsp_valid    (mem_rsp_valid),
    .mem_rsp_data     (mem_rsp_data),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_instr        (out_instr),
    .out_pc           (out_pc),
    .out_is_compressed(out_is_compressed)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0001_0001;
  endfunction

  // Advance one clock; model the memory accepting a request and answering
  // `lat` cycles later. Returns 1 time unit after the rising edge.
  task automatic step();
    logic        acc;
    logic [31:0] a;
    #1;
    acc = mem_req_valid && mem_req_ready;
    a   = mem_req_addr;
    @(posedge clk);
    #1;
    cyc++;
    mem_rsp_valid = 1'b0;
    mem_rsp_data  = 32'h0;
    if (acc) begin
      rq.push_back('{a, cyc + lat - 1});
      $display("  cyc=%0d mem req accepted addr=%h", cyc - 1, a);
    end
    if (rq.size() > 0 && rq[0].due <= cyc) begin
      mem_rsp_valid = 1'b1;
      mem_rsp_data  = mem_read(rq[0].addr);
      $display("  cyc=%0d mem rsp addr=%h data=%h", cyc, rq[0].addr, mem_rsp_data);
      void'(rq.pop_front());
    end
  endtask

  task automatic do_reset();
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    out_ready      = 1'b0;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    lat            = 1;
    rq.delete();
    step();
    step();
    rstn = 1'b1;
    #1;
  endtask

  // Run up to `budget` cycles recording up to n output handshakes.
  task automatic collect(input int n, input int budget);
    got_n = 0;
    for (int k = 0; k < 8; k++) begin
      got_instr[k] = 32'h0; got_pc[k] = 32'h0; got_c[k] = 1'b0;
    end
    for (int c = 0; c < budget && got_n < n; c++) begin
      #1;
      if (out_valid && out_ready) begin
        got_instr[got_n] = out_instr;
        got_pc[got_n]    = out_pc;
        got_c[got_n]     = out_is_compressed;
        $display("  cyc=%0d out pc=%h instr=%h c=%0d", cyc, out_pc, out_instr, out_is_compressed);
        got_n++;
      end
      step();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    redirect_valid = 1'b0; out_ready = 1'b0; mem_req_ready = 1'b1;
    #1;
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rst_req_valid: got %b want 0", mem_req_valid); end
    n_vec++; if (out_instr !== 32'h0) begin n_err++; $display("FAIL rst_out_instr: got %h want 00000000", out_instr); end
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL rst_out_pc: got %h want 00000000", out_pc); end
    n_vec++; if (out_is_compressed !== 1'b0) begin n_err++; $display("FAIL rst_out_c: got %b want 0", out_is_compressed); end
    do_reset();
    n_vec++; if (mem_req_valid !== 1'b1) begin n_err++; $display("FAIL rst_first_req_valid: got %b want 1", mem_req_valid); end
    n_vec++; if (mem_req_addr !== 32'h0) begin n_err++; $display("FAIL rst_first_req_addr: got %h want 00000000", mem_req_addr); end
  endtask

  task automatic test_reset_fetch();
    mem.delete();
    mem[32'h0] = 32'h0050_0093;
    do_reset();
    n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin n_err++; $display("FAIL rf_c1_req: got v=%b a=%h want v=1 a=00000000", mem_req_valid, mem_req_addr); end
    step();
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rf_c2_out_valid: got %b want 0", out_valid); end
    n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rf_c2_req_valid: got %b want 0", mem_req_valid); end
    step();
    n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL rf_c3_out_valid: got %b want 1", out_valid); end
    n_vec++; if (out_instr !== 32'h0050_0093) begin n_err++; $display("FAIL rf_c3_instr: got %h want 00500093", out_instr); end
    n_vec++; if (out_pc !== 32'h0) begin n_err++; $display("FAIL rf_c3_pc: got %h want 00000000", out_pc); end
    n_vec++; if (out_is_compressed !== 1'b0) begin n_err++; $display("FAIL rf_c3_c: got %b want 0", out_is_compressed); end
    n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4) begin n_err++; $display("FAIL rf_c3_req: got v=%b a=%h want v=1 a=00000004", mem_req_valid, mem_req_addr); end
  endtask

  task automatic test_mixed();
    logic [31:0] ei [3];
    logic [31:0] ep [3];
    logic        ec [3];
    ei[0] = 32'h0000_4505; ep[0] = 32'h0; ec[0] = 1'b1;
    ei[1] = 32'h0050_0093; ep[1] = 32'h2; ec[1] = 1'b0;
    ei[2] = 32'h0000_4505; ep[2] = 32'h6; ec[2] = 1'b1;
    mem.delete();
    mem[32'h0] = 32'h0093_4505;
    mem[32'h4] = 32'h4505_0050;
    do_reset();
    out_ready = 1'b1;
    collect(3, 20);
    n_vec++; if (got_n !== 3) begin n_err++; $display("FAIL mix_count: got %0d want 3", got_n); end
    for (int k = 0; k < 3; k++) begin
      n_vec++; if (got_instr[k] !== ei[k]) begin n_err++; $display("FAIL mix_instr[%0d]: got %h want %h", k, got_instr[k], ei[k]); end
      n_vec++; if (got_pc[k] !== ep[k]) begin n_err++; $display("FAIL mix_pc[%0d]: got %h want %h", k, got_pc[k], ep[k]); end
      n_vec++; if (got_c[k] !== ec[k]) begin n_err++; $display("FAIL mix_c[%0d]: got %b want %b", k, got_c[k], ec[k]); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_outstanding();
    mem.delete();
    mem[32'h8]   = 32'h1234_5678;
    mem[32'h100] = 32'h4505_0093;
    do_reset();
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8;
    #1;
    n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdo_gate_req: got %b want 0", mem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8) begin n_err++; $display("FAIL rdo_req8: got v=%b a=%h want v=1 a=00000008", mem_req_valid, mem_req_addr); end
    lat = 2;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h102;
    #1;
    n_vec++; if (mem_req_valid !== 1'b0 || out_valid !== 1'b0) begin n_err++; $display("FAIL rdo_redir_gate: got req=%b out=%b want 0 0", mem_req_valid, out_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdo_wait_stale: got req=%b want 0", mem_req_valid); end
    step();
    #1;
    n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100) begin n_err++; $display("FAIL rdo_req100: got v=%b a=%h want v=1 a=00000100", mem_req_valid, mem_req_addr); end
    collect(1, 12);
    n_vec++; if (got_n !== 1) begin n_err++; $display("FAIL rdo_count: got %0d want 1", got_n); end
    n_vec++; if (got_instr[0] !== 32'h0000_4505) begin n_err++; $display("FAIL rdo_instr: got %h want 00004505", got_instr[0]); end
    n_vec++; if (got_pc[0] !== 32'h102) begin n_err++; $display("FAIL rdo_pc: got %h want 00000102", got_pc[0]); end
    n_vec++; if (got_c[0] !== 1'b1) begin n_err++; $display("FAIL rdo_c: got %b want 1", got_c[0]); end
    out_ready = 1'b0;
  endtask

  task automatic test_redirect_coincident();
    mem.delete();
    mem[32'h0]   = 32'h0093_4505;
    mem[32'h204] = 32'h0005_0009;
    do_reset();
    out_ready = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h205;
    #1;
    n_vec++; if (mem_rsp_valid !== 1'b1) begin n_err++; $display("FAIL rdc_setup_rsp: got %b want 1", mem_rsp_valid); end
    n_vec++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0) begin n_err++; $display("FAIL rdc_gate: got out=%b req=%b want 0 0", out_valid, mem_req_valid); end
    step();
    redirect_valid = 1'b0;
    #1;
    n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h204) begin n_err++; $display("FAIL rdc_req: got v=%b a=%h want v=1 a=00000204", mem_req_valid, mem_req_addr); end
    n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rdc_no_out: got %b want 0", out_valid); end
    collect(1, 10);
    n_vec++; if (got_pc[0] !== 32'h204 || got_instr[0] !== 32'h0000_0009) begin n_err++; $display("FAIL rdc_first_out: got pc=%h instr=%h want pc=00000204 instr=00000009", got_pc[0], got_instr[0]); end
    out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [31:0] ei [6];
    ei[0] = 32'h1; ei[1] = 32'h5; ei[2] = 32'h9; ei[3] = 32'hd; ei[4] = 32'h11; ei[5] = 32'h15;
    mem.delete();
    mem[32'h0] = 32'h0005_0001;
    mem[32'h4] = 32'h000d_0009;
    mem[32'h8] = 32'h0015_0011;
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    for (int i = 0; i < 6; i++) begin
      #1;
      n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'h1 || out_pc !== 32'h0) begin n_err++; $display("FAIL bp_hold[%0d]: got v=%b instr=%h pc=%h want v=1 instr=00000001 pc=00000000", i, out_valid, out_instr, out_pc); end
      if (i >= 1) begin
        n_vec++; if (mem_req_valid !== 1'b0) begin n_err++; $display("FAIL bp_no_req[%0d]: got %b want 0", i, mem_req_valid); end
      end
      step();
    end
    out_ready = 1'b1;
    collect(6, 30);
    n_vec++; if (got_n !== 6) begin n_err++; $display("FAIL bp_count: got %0d want 6", got_n); end
    for (int k = 0; k < 6; k++) begin
      n_vec++; if (got_instr[k] !== ei[k] || got_pc[k] !== 32'(2 * k) || got_c[k] !== 1'b1) begin n_err++; $display("FAIL bp_drain[%0d]: got instr=%h pc=%h c=%b want instr=%h pc=%h c=1", k, got_instr[k], got_pc[k], got_c[k], ei[k], 32'(2 * k)); end
    end
    out_ready = 1'b0;
  endtask

  task automatic test_stall_reset();
    mem.delete();
    mem[32'h0] = 32'h0050_0093;
    mem[32'h4] = 32'h1234_5679;
    do_reset();
    out_ready = 1'b0;
    step();
    step();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h4) begin n_err++; $display("FAIL st_hold[%0d]: got v=%b a=%h want v=1 a=00000004", i, mem_req_valid, mem_req_addr); end
      n_vec++; if (out_valid !== 1'b1 || out_instr !== 32'h0050_0093) begin n_err++; $display("FAIL st_out[%0d]: got v=%b instr=%h want v=1 instr=00500093", i, out_valid, out_instr); end
      step();
    end
    mem_req_ready = 1'b1;
    lat = 2;
    step();
    rstn = 1'b0;
    #1;
    n_vec++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || out_pc !== 32'h0) begin n_err++; $display("FAIL st_async_rst: got out=%b req=%b pc=%h want 0 0 00000000", out_valid, mem_req_valid, out_pc); end
    step();
    n_vec++; if (out_valid !== 1'b0 || mem_req_valid !== 1'b0 || out_pc !== 32'h0) begin n_err++; $display("FAIL st_rst_next: got out=%b req=%b pc=%h want 0 0 00000000", out_valid, mem_req_valid, out_pc); end
    rstn = 1'b1;
    #1;
    n_vec++; if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h0) begin n_err++; $display("FAIL st_restart_req: got v=%b a=%h want v=1 a=00000000", mem_req_valid, mem_req_addr); end
    out_ready = 1'b1;
    collect(1, 12);
    n_vec++; if (got_n !== 1 || got_instr[0] !== 32'h0050_0093 || got_pc[0] !== 32'h0 || got_c[0] !== 1'b0) begin n_err++; $display("FAIL st_first_out: got n=%0d instr=%h pc=%h c=%b want n=1 instr=00500093 pc=00000000 c=0", got_n, got_instr[0], got_pc[0], got_c[0]); end
    out_ready = 1'b0;
  endtask

  initial begin
    rstn           = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    mem_req_ready  = 1'b1;
    mem_rsp_valid  = 1'b0;
    mem_rsp_data   = 32'h0;
    out_ready      = 1'b0;
    test_reset();
    test_reset_fetch();
    test_mixed();
    test_redirect_outstanding();
    test_redirect_coincident();
    test_backpressure();
    test_stall_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
